imem_loader: RTL and testbench

- Writer side of the instruction memory: fills the memory that the fetch path reads.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive word addresses, starting at BASE_ADDR. Addresses are word-indexed, matching the PC's +1 increment.
- Holds the CPU (cpu_hold) from reset until a load completes successfully.

---
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream receive channel and instruction-memory write port of the loader.
// The master side drives the stream; the slave side is the loader itself.
interface imem_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a 16-bit word count followed by big-endian words
// from a byte stream, writes them to consecutive word addresses and holds the CPU until done.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state_reg, state_next;
  logic [15:0] length_reg, length_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [23:0] shift_reg, shift_next;
  logic        rx_ready_reg, rx_ready_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        hold_reg, hold_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [15:0] words_reg, words_next;
  logic        accept;
  logic [15:0] words_inc;

  assign accept    = bus.rx_valid && rx_ready_reg;
  assign words_inc = words_reg + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      length_reg   <= 16'd0;
      byte_cnt_reg <= 2'd0;
      shift_reg    <= 24'd0;
      rx_ready_reg <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= BASE_ADDR;
      wdata_reg    <= 32'd0;
      hold_reg     <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      words_reg    <= 16'd0;
    end else begin
      state_reg    <= state_next;
      length_reg   <= length_next;
      byte_cnt_reg <= byte_cnt_next;
      shift_reg    <= shift_next;
      rx_ready_reg <= rx_ready_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      hold_reg     <= hold_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      words_reg    <= words_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    length_next   = length_reg;
    byte_cnt_next = byte_cnt_reg;
    shift_next    = shift_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    hold_next     = hold_reg;
    done_next     = done_reg;
    err_next      = err_reg;
    words_next    = words_reg;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_next    = LEN_HI;
          done_next     = 1'b0;
          err_next      = 1'b0;
          words_next    = 16'd0;
          byte_cnt_next = 2'd0;
          hold_next     = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) begin
          length_next = {bus.rx_data, length_reg[7:0]};
          state_next  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          length_next = {length_reg[15:8], bus.rx_data};
          if (length_next == 16'd0) begin
            state_next = DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else if ({1'b0, length_next} > MAX_LEN) begin
            state_next = ERR;
            err_next   = 1'b1;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          shift_next    = {shift_reg[15:0], bus.rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          // The 4th byte goes straight into the write register so WRITE follows immediately.
          if (byte_cnt_reg == 2'd3) begin
            state_next = WRITE;
            we_next    = 1'b1;
            addr_next  = BASE_ADDR + {16'd0, words_reg};
            wdata_next = {shift_reg, bus.rx_data};
          end
        end
      end
      WRITE: begin
        words_next = words_inc;
        if (words_inc == length_reg) begin
          state_next = DONE;
          done_next  = 1'b1;
          hold_next  = 1'b0;
        end else begin
          state_next = DATA;
        end
      end
      default: state_next = IDLE;
    endcase

    rx_ready_next = (state_next == LEN_HI) || (state_next == LEN_LO) || (state_next == DATA);
  end

  assign bus.rx_ready   = rx_ready_reg;
  assign bus.imem_we    = we_reg;
  assign bus.imem_addr  = addr_reg;
  assign bus.imem_wdata = wdata_reg;
  assign cpu_hold       = hold_reg;
  assign load_done      = done_reg;
  assign load_err       = err_reg;
  assign words_written  = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives headers and word streams with random data and gaps,
// and compares memory writes and status against a list built from the load rules.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, load_done, load_err;
  logic [15:0] words_written;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus.slave),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [63:0] cap_q[$];
  bit          ready_bad;

  logic [31:0] basic_words[$] = '{32'h24080005, 32'hAC090010};
  logic [31:0] one_word[$]    = '{32'hDEADBEEF};
  logic [31:0] no_words[$];

  // Every write is logged; rx_ready must be low whenever a write is in progress.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      cap_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (bus.rx_ready !== 1'b0) ready_bad = 1'b1;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte; it transfers on the rising edge after a negedge that sees rx_ready high.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout = 1'b1;
        break;
      end
    end
    if (!timeout) @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_end(output bit timeout);
    int n;
    n = 0;
    timeout = 1'b0;
    while (load_done !== 1'b1 && load_err !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_hold, bus.rx_ready, load_done, load_err, bus.imem_we} !== 5'b10000) $display("FAIL reset_flags got=%b exp=10000", {cpu_hold, bus.rx_ready, load_done, load_err, bus.imem_we});
    else passed++;
    checks++;
    if ({bus.imem_addr, bus.imem_wdata, words_written} !== {BASE, 32'd0, 16'd0}) $display("FAIL reset_regs got addr=%h data=%h words=%0d", bus.imem_addr, bus.imem_wdata, words_written);
    else passed++;
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (cap_q.size() != 0) $display("FAIL idle_no_write got=%0d writes exp=0", cap_q.size());
    else passed++;
    checks++;
    if ({cpu_hold, bus.rx_ready, load_done} !== 3'b100) $display("FAIL idle_flags got=%b exp=100", {cpu_hold, bus.rx_ready, load_done});
    else passed++;
  endtask

  // gap_mode: 0 = rx_valid held high, 1 = three idle cycles per byte, 2 = random gaps.
  task automatic test_load(input string name, input logic [15:0] len, input logic [31:0] given[$],
                           input int gap_mode, input bit inject_start);
    logic [31:0] words[$];
    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];
    bit          to;
    bit          legal;
    int          gap;
    int          exp_cnt;

    legal   = (len <= 16'd256);
    exp_cnt = legal ? int'(len) : 0;
    stream.push_back(len[15:8]);
    stream.push_back(len[7:0]);
    for (int i = 0; i < exp_cnt; i++) begin
      words.push_back((i < given.size()) ? given[i] : $urandom);
      stream.push_back(words[i][31:24]);
      stream.push_back(words[i][23:16]);
      stream.push_back(words[i][15:8]);
      stream.push_back(words[i][7:0]);
      exp_q.push_back({BASE + 32'(i), words[i]});
    end

    cap_q.delete();
    ready_bad = 1'b0;
    pulse_start();
    to = 1'b0;
    for (int k = 0; k < stream.size(); k++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(0, 3));
      send_byte(stream[k], gap, to);
      if (to) break;
      if (inject_start && k == 3) pulse_start();
    end
    if (!to) wait_end(to);
    @(negedge clk);

    checks++;
    if (to) $display("FAIL %s_timeout got=timeout exp=completion", name);
    else passed++;
    checks++;
    if (cap_q.size() != exp_q.size()) $display("FAIL %s_write_count got=%0d exp=%0d", name, cap_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== exp_q[i]) $display("FAIL %s_write%0d got addr=%h data=%h exp addr=%h data=%h", name, i, cap_q[i][63:32], cap_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
      else passed++;
    end
    checks++;
    if ({load_done, load_err, cpu_hold} !== {legal, !legal, !legal}) $display("FAIL %s_status got=%b exp=%b", name, {load_done, load_err, cpu_hold}, {legal, !legal, !legal});
    else passed++;
    checks++;
    if (words_written !== 16'(exp_cnt)) $display("FAIL %s_words_written got=%0d exp=%0d", name, words_written, exp_cnt);
    else passed++;
    checks++;
    if (ready_bad) $display("FAIL %s_ready_in_write got=1 exp=0", name);
    else passed++;
    $display("load %s len=%0d writes=%0d done=%b err=%b", name, len, cap_q.size(), load_done, load_err);
  endtask

  task automatic test_start_with_valid();
    bit to;
    cap_q.delete();
    start = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0, to);
    if (!to) send_byte(8'h01, 0, to);
    if (!to) send_byte(8'h12, 0, to);
    if (!to) send_byte(8'h34, 0, to);
    if (!to) send_byte(8'h56, 0, to);
    if (!to) send_byte(8'h78, 0, to);
    if (!to) wait_end(to);
    @(negedge clk);
    checks++;
    if (to || cap_q.size() != 1) $display("FAIL start_valid_count got=%0d timeout=%b exp=1", cap_q.size(), to);
    else passed++;
    checks++;
    if (cap_q.size() > 0 && cap_q[0] !== {BASE, 32'h12345678}) $display("FAIL start_valid_word got=%h exp=%h", cap_q[0], {BASE, 32'h12345678});
    else passed++;
    checks++;
    if ({load_done, load_err} !== 2'b10) $display("FAIL start_valid_status got=%b exp=10", {load_done, load_err});
    else passed++;
    $display("load start_with_valid writes=%0d", cap_q.size());
  endtask

  task automatic test_reset_midload();
    bit to;
    logic [7:0] bytes[$] = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    cap_q.delete();
    pulse_start();
    to = 1'b0;
    for (int k = 0; k < bytes.size() && !to; k++) send_byte(bytes[k], 0, to);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cpu_hold, bus.rx_ready, load_done, load_err, bus.imem_we} !== 5'b10000) $display("FAIL midreset_flags got=%b exp=10000", {cpu_hold, bus.rx_ready, load_done, load_err, bus.imem_we});
    else passed++;
    checks++;
    if ({bus.imem_addr, bus.imem_wdata, words_written} !== {BASE, 32'd0, 16'd0}) $display("FAIL midreset_regs got addr=%h data=%h words=%0d", bus.imem_addr, bus.imem_wdata, words_written);
    else passed++;
    checks++;
    if (to || cap_q.size() != 1 || cap_q[0] !== {BASE, 32'hA1B2C3D4}) $display("FAIL midreset_writes got=%0d writes timeout=%b exp=1 write of a1b2c3d4", cap_q.size(), to);
    else passed++;
    $display("reset mid-load writes_before_reset=%0d", cap_q.size());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_load("after_reset", 16'd1, one_word, 0, 1'b0);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_load("basic", 16'd2, basic_words, 0, 1'b0);
    test_load("stall", 16'd2, basic_words, 1, 1'b0);
    test_load("empty", 16'd0, no_words, 0, 1'b0);
    test_load("too_long", 16'd257, no_words, 0, 1'b0);
    test_load("recover", 16'd1, one_word, 0, 1'b0);
    test_load("max", 16'd256, no_words, 0, 1'b0);
    for (int r = 0; r < 5; r++) test_load("random", 16'($urandom_range(1, 6)), no_words, 2, 1'b1);
    test_start_with_valid();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
